// File: rtl/fetch_predict_pkg.sv
// fetch_predict_pkg: shared widths, opcodes, BHT reset value and immediate decoders.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
package fetch_predict_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] BHT_INIT = 2'b01;
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_predict_bht.sv
// bht: table of 2-bit saturating counters, combinational read, trained on posedge.
module bht
  import fetch_predict_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             train_en,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);
  logic [1:0] ctr [2**IDX_W];
  logic [1:0] cur, nxt;
  assign rd_ctr = ctr[rd_idx];
  always_comb begin
    cur = ctr[train_idx];
    nxt = train_taken ? (&cur ? cur : cur + 2'd1) : (|cur ? cur - 2'd1 : cur);
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      for (int k = 0; k < 2**IDX_W; k++) ctr[k] <= BHT_INIT;
    else if (train_en)
      ctr[train_idx] <= nxt;
  end
endmodule

// File: rtl/fetch_predict.sv
// fetch_predict: fetch PC register with predecode and next-PC prediction.
// Define BHT_EN for a 2-bit counter BHT; otherwise branches use static BTFN.
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int BHT_IDX_W = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    F_stall_i,
  input  logic                    E_redirect_i,
  input  logic [`PC_WIDTH-1:0]    E_redirect_PC_i,
  input  logic [`INSTR_WIDTH-1:0] F_instr_i,
  input  logic                    E_train_vaild_i,
  input  logic [`PC_WIDTH-1:0]    E_train_PC_i,
  input  logic                    E_train_taken_i,
  output logic [`PC_WIDTH-1:0]    F_PC_o,
  output logic [`PC_WIDTH-1:0]    F_nPC_o,
  output logic                    F_predict_o,
  output logic                    F_train_vaild_o
);
  logic [`PC_WIDTH-1:0] pc;
  logic is_jal, is_br, br_taken;
  logic [31:0] j_off, b_off;
`ifdef BHT_EN
  logic [1:0] ctr;
  logic unused_train_pc;
  assign unused_train_pc = ^{E_train_PC_i[31:BHT_IDX_W+2], E_train_PC_i[1:0]};
  bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_idx     (pc[BHT_IDX_W+1:2]),
    .rd_ctr     (ctr),
    .train_en   (E_train_vaild_i),
    .train_idx  (E_train_PC_i[BHT_IDX_W+1:2]),
    .train_taken(E_train_taken_i)
  );
  assign br_taken = ctr[1];
`else
  logic unused_train;
  assign unused_train = ^{E_train_vaild_i, E_train_PC_i, E_train_taken_i};
  // backward branches taken, forward not taken
  assign br_taken = b_off[31];
`endif
  always_comb begin
    is_jal = F_instr_i[6:0] == OP_JAL;
    is_br = F_instr_i[6:0] == OP_BRANCH;
    j_off = imm_j(F_instr_i);
    b_off = imm_b(F_instr_i);
    F_PC_o = pc;
    F_predict_o = is_jal | (is_br & br_taken);
    F_train_vaild_o = is_br;
    F_nPC_o = pc + (is_jal ? j_off : (is_br && br_taken) ? b_off : 32'd4);
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else if (E_redirect_i) pc <= E_redirect_PC_i;
    else if (!F_stall_i) pc <= F_nPC_o;
  end
endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter BHT_IDX_W, default 6, the BHT index width (2^BHT_IDX_W entries).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port F_stall_i, input, 1 bit: hold the PC.
REQ-006 SHALL have port E_redirect_i, input, 1 bit: mispredict or jalr correction from execute.
REQ-007 SHALL have port E_redirect_PC_i, input, `PC_WIDTH bits: corrected PC.
REQ-008 SHALL have port F_instr_i, input, `INSTR_WIDTH bits: imem read data for F_PC_o, same cycle.
REQ-009 SHALL have port E_train_vaild_i, input, 1 bit: resolved B-type present.
REQ-010 SHALL have port E_train_PC_i, input, `PC_WIDTH bits: PC of the resolved branch.
REQ-011 SHALL have port E_train_taken_i, input, 1 bit: actual branch outcome.
REQ-012 SHALL have port F_PC_o, output, `PC_WIDTH bits: current fetch PC, also the imem address.
REQ-013 SHALL have port F_nPC_o, output, `PC_WIDTH bits: predicted next PC.
REQ-014 SHALL have port F_predict_o, output, 1 bit: predicted taken.
REQ-015 SHALL have port F_train_vaild_o, output, 1 bit: instruction is B-type; carried down the pipe for training.

Function
REQ-016 SHALL hold the PC in a register; F_PC_o is the register output.
REQ-017 SHALL apply PC update priority: E_redirect_i loads E_redirect_PC_i; else ~F_stall_i loads F_nPC_o; else the PC holds. Redirect wins over stall.
REQ-018 SHALL predecode F_instr_i combinationally: opcode 7'b1101111 is JAL; opcode 7'b1100011 is B-type; everything else, including JALR, is sequential.
REQ-019 SHALL set F_nPC_o: JAL gives PC+immJ; B-type predicted taken gives PC+immB; otherwise PC+4. All adds are modulo 2^32, so wrap-around is allowed.
REQ-020 SHALL drive F_predict_o=1 for JAL and for a B-type predicted taken, and 0 otherwise.
REQ-021 SHALL drive F_train_vaild_o=1 only for B-type.
REQ-022 SHALL read the BHT combinationally at index F_PC_o[BHT_IDX_W+1:2]; B-type is predicted taken when counter[1]=1.
REQ-023 SHALL, when E_train_vaild_i=1, update the entry at E_train_PC_i[BHT_IDX_W+1:2] on posedge: taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
REQ-024 SHALL perform training independent of F_stall_i and E_redirect_i.
REQ-025 SHALL, when the read and train indices are equal in the same cycle, return the pre-update value (no bypass).
REQ-026 SHALL produce zero-latency outputs: prediction for F_PC_o is valid in the same cycle F_instr_i arrives.

Reset
REQ-027 SHALL, while rst_n=0 and without waiting for a clock edge, set PC=RESET_PC and set every BHT counter to 2'b01 (weakly not-taken).
REQ-028 SHALL, on reset mid-operation, discard a pending redirect or train in that cycle.
REQ-029 SHALL resume fetching at RESET_PC on the first posedge after rst_n rises.

Configuration
REQ-030 SHALL, with BHT_EN defined, instantiate the BHT and predict as in REQ-022/023.
REQ-031 SHALL, with BHT_EN undefined, omit the BHT and use static BTFN: B-type is predicted taken iff immB<0; train inputs are ignored. JAL is unaffected.

Structure
REQ-032 SHALL place opcode constants (OP_JAL, OP_BRANCH) and the counter reset value (BHT_INIT) in the shared define file, alongside `PC_WIDTH and `INSTR_WIDTH.
REQ-033 SHALL implement the counter table as sub-module bht (read port, train port, async reset).

Verification
REQ-034 SHALL verify reset: assert rst_n=0 mid-run -> F_PC_o=32'h8000_0000 immediately; F_instr_i=32'h00000013 -> F_nPC_o=32'h8000_0004, F_predict_o=0.
REQ-035 SHALL verify JAL: PC=32'h8000_0000, F_instr_i=32'h0080006F -> F_nPC_o=32'h8000_0008, F_predict_o=1, F_train_vaild_o=0.
REQ-036 SHALL verify training: beq 32'hFE0008E3 at 32'h8000_0010, initially predicted not-taken (nPC 32'h8000_0014). After 1 taken train -> 2'b10, nPC 32'h8000_0000. After 4 more taken trains -> 2'b11 (saturated). After 1 not-taken train -> 2'b10, still taken. After 2 further not-taken trains -> 2'b00, nPC 32'h8000_0014.
REQ-037 SHALL verify simultaneous redirect and stall: E_redirect_i=1, F_stall_i=1, E_redirect_PC_i=32'h8000_0100 -> next F_PC_o=32'h8000_0100.
REQ-038 SHALL verify same-index train and read: a taken train issued while fetching that PC -> prediction uses the old counter, and the next cycle uses the new counter.
REQ-039 SHALL verify the BHT_EN-undefined build: 32'hFE0008E3 predicted taken; a forward beq at +16 predicted not-taken; train inputs have no effect.
